// File: rtl/uart_controller.sv
// uart_controller: UART command receiver driving light/fan/alarm enables; optional echo on tx via `UART_CTRL_ECHO_EN
module uart_controller #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] data_out,
    output logic       light_control,
    output logic       fan_control,
    output logic       alarm_control
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          r_rx_s1, r_rx_s2, r_rx_d;
    state_t        r_rx_state, w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_byte;
    logic          r_rx_done;
    logic          w_rx_fall, w_rx_tick, w_rx_valid;

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst)
        if (!rst) {r_rx_s1, r_rx_s2, r_rx_d} <= 3'b111;
        else      {r_rx_s1, r_rx_s2, r_rx_d} <= {rx, r_rx_s1, r_rx_s2};

    // rx state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_rx_state <= S_IDLE;
        else      r_rx_state <= w_rx_next;

    // rx next state: half-bit start check, eight mid-bit data samples, one stop sample
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
            default: if (w_rx_tick) w_rx_next = S_IDLE;
        endcase
    end

    // rx strobes: edge, sample point, and a well-framed stop bit
    always_comb begin
        w_rx_fall  = r_rx_d & ~r_rx_s2;
        w_rx_tick  = (r_rx_state == S_START) ? (r_rx_cnt == HALF) : (r_rx_cnt == FULL);
        w_rx_valid = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;
    end

    // rx bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_rx_cnt  <= '0;
            r_rx_bit  <= 3'd0;
            r_rx_byte <= 8'h00;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_cnt  <= (r_rx_state == S_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
            r_rx_bit  <= (r_rx_state != S_DATA) ? 3'd0 : r_rx_bit + {2'b00, w_rx_tick};
            if (r_rx_state == S_DATA && w_rx_tick) r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
            r_rx_done <= w_rx_valid;
        end

    // commit a valid byte and apply its command to the level outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            data_out      <= 8'h00;
            light_control <= 1'b0;
            fan_control   <= 1'b0;
            alarm_control <= 1'b0;
        end else if (r_rx_done) begin
            data_out      <= r_rx_byte;
            light_control <= (r_rx_byte == 8'h4C) ? 1'b1 : (r_rx_byte == 8'h6C) ? 1'b0 : light_control;
            fan_control   <= (r_rx_byte == 8'h46) ? 1'b1 : (r_rx_byte == 8'h66) ? 1'b0 : fan_control;
            alarm_control <= (r_rx_byte == 8'h41) ? 1'b1 : (r_rx_byte == 8'h61) ? 1'b0 : alarm_control;
        end

`ifdef UART_CTRL_ECHO_EN
    state_t        r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift, r_hold;
    logic          r_hold_valid;
    logic          w_tx_tick, w_tx_load, w_cmd;

    // recognized commands echo themselves, anything else answers '?'
    always_comb
        w_cmd = (r_rx_byte == 8'h4C) || (r_rx_byte == 8'h6C) || (r_rx_byte == 8'h46) ||
                (r_rx_byte == 8'h66) || (r_rx_byte == 8'h41) || (r_rx_byte == 8'h61);

    // tx state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_tx_state <= S_IDLE;
        else      r_tx_state <= w_tx_next;

    // tx next state: leave idle whenever a response is parked
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (r_hold_valid) w_tx_next = S_START;
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
            default: if (w_tx_tick) w_tx_next = S_IDLE;
        endcase
    end

    // tx outputs: line level per state, bit strobe and hold-register pickup
    always_comb begin
        w_tx_tick = (r_tx_cnt == FULL);
        w_tx_load = (r_tx_state == S_IDLE) && r_hold_valid;
        tx        = (r_tx_state == S_START) ? 1'b0 : (r_tx_state == S_DATA) ? r_tx_shift[0] : 1'b1;
    end

    // tx timer, shifter and one-deep response holding register (newest wins)
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_tx_cnt     <= '0;
            r_tx_bit     <= 3'd0;
            r_tx_shift   <= 8'h00;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
        end else begin
            r_tx_cnt     <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            r_tx_bit     <= (r_tx_state != S_DATA) ? 3'd0 : r_tx_bit + {2'b00, w_tx_tick};
            if (w_tx_load) r_tx_shift <= r_hold;
            else if (r_tx_state == S_DATA && w_tx_tick) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_hold_valid <= r_rx_done | (r_hold_valid & ~w_tx_load);
            if (r_rx_done) r_hold <= w_cmd ? r_rx_byte : 8'h3F;
        end
`else
    assign tx = 1'b1;
`endif
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: randomized and directed frames against a command-level reference model
module tb_uart_controller;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       tx;
    logic [7:0] data_out;
    logic       light_control, fan_control, alarm_control;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_light = 1'b0;
    logic       m_fan   = 1'b0;
    logic       m_alarm = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mb;

    uart_controller #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .data_out(data_out),
        .light_control(light_control), .fan_control(fan_control), .alarm_control(alarm_control)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mb[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            got_q.push_back(mb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_data"},  {24'd0, data_out}, {24'd0, m_data});
        chk({tag, "_light"}, {31'd0, light_control}, {31'd0, m_light});
        chk({tag, "_fan"},   {31'd0, fan_control},   {31'd0, m_fan});
        chk({tag, "_alarm"}, {31'd0, alarm_control}, {31'd0, m_alarm});
    endtask

    function automatic void model(input logic [7:0] b);
        m_data = b;
        case (b)
            8'h4C: m_light = 1'b1;
            8'h6C: m_light = 1'b0;
            8'h46: m_fan   = 1'b1;
            8'h66: m_fan   = 1'b0;
            8'h41: m_alarm = 1'b1;
            8'h61: m_alarm = 1'b0;
            default: ;
        endcase
`ifdef UART_CTRL_ECHO_EN
        exp_q.push_back((b inside {8'h4C, 8'h6C, 8'h46, 8'h66, 8'h41, 8'h61}) ? b : 8'h3F);
`endif
    endfunction

    function automatic void model_reset();
        m_data  = 8'h00;
        m_light = 1'b0;
        m_fan   = 1'b0;
        m_alarm = 1'b0;
    endfunction

    task automatic frame(input logic [7:0] b, input logic good);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!good) repeat (2) @(negedge clk);
        if (good) model(b);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk_state(tag);
        chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic [7:0] cmds [6];
        logic [7:0] b;
        logic       good;
        int         n;
        cmds = '{8'h4C, 8'h6C, 8'h46, 8'h66, 8'h41, 8'h61};

        repeat (3) @(negedge clk);
        chk_state("reset");
        chk("reset_tx", {31'd0, tx}, 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        frame(8'h4C, 1'b1); chk_state("L");
        frame(8'h46, 1'b1); chk_state("F");
        frame(8'h41, 1'b1); chk_state("A");
        frame(8'h6C, 1'b1); chk_state("l");
        frame(8'h66, 1'b1); chk_state("f");
        frame(8'h61, 1'b1); chk_state("a");

        frame(8'h4C, 1'b1);
        frame(8'h46, 1'b1);
        frame(8'h99, 1'b1); chk_state("unknown99");

        frame(8'h6C, 1'b1);
        frame(8'h4C, 1'b0); chk_state("framing_err");

        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk_state("glitch");

        frame(8'h46, 1'b1);
        frame(8'h66, 1'b1); chk_state("b2b_Ff");

        for (int k = 0; k < 12; k++) begin
            b    = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            frame(b, good);
            chk_state("random");
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end

        frame(8'h4C, 1'b1);
        frame(8'h46, 1'b1);
        frame(8'h41, 1'b1);
        repeat (400) @(negedge clk);
        async_reset("midsim_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        frame(8'h41, 1'b1); chk_state("after_reset");

        repeat (400) @(negedge clk);
        rx = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        async_reset("midframe_reset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk_state("aborted_frame");
        frame(8'h46, 1'b1); chk_state("recover");

        repeat (500) @(negedge clk);
        chk("echo_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("echo_byte", {24'd0, got_q[i]}, {24'd0, exp_q[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
